fft4_framer: RTL and testbench

Upstream input stage for the 4-point FFT datapath. Accepts a serial stream of signed complex samples over a valid/ready handshake and packs each group of four into a parallel frame. The frame is presented on `x0..x3` ports that connect directly to `fft_4point` inputs. Two ping-pong frame banks allow one frame to fill while the previous one is held stable for the combinational FFT and its consumer.

---
 rtl/fft_pkg.sv | 12 +
 rtl/fft4_frame_bank.sv | 25 ++
 rtl/fft4_framer.sv | 116 +++++++++++
 tb/tb_fft4_framer.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared sample and frame types for the 4-point FFT datapath
package fft_pkg;
    localparam int DATA_W = 16;
    localparam int FFT_N  = 4;

    typedef struct packed {
        logic signed [DATA_W-1:0] re;
        logic signed [DATA_W-1:0] im;
    } cplx_t;

    typedef cplx_t frame_t [FFT_N];
endpackage

// File: rtl/fft4_frame_bank.sv
// rtl/fft4_frame_bank.sv - four-entry complex register bank, indexed write, parallel read
module fft4_frame_bank
    import fft_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       we_i,
    input  logic [1:0] idx_i,
    input  cplx_t      wdata_i,
    output frame_t     rdata_o
);
    frame_t mem_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FFT_N; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[idx_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q;
endmodule

// File: rtl/fft4_framer.sv
// rtl/fft4_framer.sv - packs a serial complex sample stream into ping-pong 4-sample frames
module fft4_framer
    import fft_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic signed [DATA_W-1:0] s_real,
    input  logic signed [DATA_W-1:0] s_imag,
    input  logic                     s_last,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic signed [DATA_W-1:0] x0_real,
    output logic signed [DATA_W-1:0] x0_imag,
    output logic signed [DATA_W-1:0] x1_real,
    output logic signed [DATA_W-1:0] x1_imag,
    output logic signed [DATA_W-1:0] x2_real,
    output logic signed [DATA_W-1:0] x2_imag,
    output logic signed [DATA_W-1:0] x3_real,
    output logic signed [DATA_W-1:0] x3_imag,
    output logic                     err_align
);
    logic [1:0] full_q, full_d;
    logic [1:0] wr_idx_q, wr_idx_d;
    logic       wr_bank_q, wr_bank_d;
    logic       rd_bank_q, rd_bank_d;
    logic       err_q, err_d;
    logic       accept, pop;
    cplx_t      wdata;
    frame_t     bank0_rd, bank1_rd, rd_frame;

    assign s_ready   = !full_q[wr_bank_q];
    assign m_valid   = full_q[rd_bank_q];
    assign err_align = err_q;
    assign accept    = s_valid && s_ready;
    assign pop       = m_valid && m_ready;
    assign wdata     = {s_real, s_imag};

    // Partial-frame samples land in the bank too; they are simply overwritten after a discard.
    fft4_frame_bank u_bank0 (
        .clk     (clk),
        .rst     (rst),
        .we_i    (accept && !wr_bank_q),
        .idx_i   (wr_idx_q),
        .wdata_i (wdata),
        .rdata_o (bank0_rd)
    );

    fft4_frame_bank u_bank1 (
        .clk     (clk),
        .rst     (rst),
        .we_i    (accept && wr_bank_q),
        .idx_i   (wr_idx_q),
        .wdata_i (wdata),
        .rdata_o (bank1_rd)
    );

    always_comb begin
        full_d    = full_q;
        wr_idx_d  = wr_idx_q;
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        err_d     = 1'b0;
        if (accept) begin
            if (wr_idx_q == 2'd3) begin
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = !wr_bank_q;
                wr_idx_d          = 2'd0;
                err_d             = !s_last;
            end else if (s_last) begin
                wr_idx_d = 2'd0;
                err_d    = 1'b1;
            end else begin
                wr_idx_d = wr_idx_q + 2'd1;
            end
        end
        // A completing bank is never full and the popped bank always is, so the two never collide.
        if (pop) begin
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = !rd_bank_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full_q    <= 2'b00;
            wr_idx_q  <= 2'd0;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            full_q    <= full_d;
            wr_idx_q  <= wr_idx_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        if (rd_bank_q) rd_frame = bank1_rd;
        else           rd_frame = bank0_rd;
    end

    assign x0_real = rd_frame[0].re;
    assign x0_imag = rd_frame[0].im;
    assign x1_real = rd_frame[1].re;
    assign x1_imag = rd_frame[1].im;
    assign x2_real = rd_frame[2].re;
    assign x2_imag = rd_frame[2].im;
    assign x3_real = rd_frame[3].re;
    assign x3_imag = rd_frame[3].im;
endmodule

// File: tb/tb_fft4_framer.sv
// tb/tb_fft4_framer.sv - directed self-checking bench for fft4_framer
module tb_fft4_framer;
    localparam int W = 16;

    typedef logic signed [3:0][15:0] quad_t;
    typedef struct packed {
        logic               v;
        logic signed [15:0] re;
        logic signed [15:0] im;
        logic               last;
        logic               mr;
        logic               e_sr;
        logic               e_mv;
        logic               e_err;
        logic               cx;
        quad_t              xr;
        quad_t              xi;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic s_valid = 1'b0, s_last = 1'b0, m_ready = 1'b0;
    logic signed [W-1:0] s_real = '0, s_imag = '0;
    logic s_ready, m_valid, err_align;
    logic signed [W-1:0] x0_real, x0_imag, x1_real, x1_imag;
    logic signed [W-1:0] x2_real, x2_imag, x3_real, x3_imag;

    int errors = 0;
    int checks = 0;
    vec_t tbl [22];

    always #5 clk = ~clk;

    fft4_framer #(.DATA_W(W)) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_real(s_real), .s_imag(s_imag), .s_last(s_last),
        .m_valid(m_valid), .m_ready(m_ready),
        .x0_real(x0_real), .x0_imag(x0_imag), .x1_real(x1_real), .x1_imag(x1_imag),
        .x2_real(x2_real), .x2_imag(x2_imag), .x3_real(x3_real), .x3_imag(x3_imag),
        .err_align(err_align)
    );

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int gxr(input int k);
        case (k)
            0: return int'(x0_real);
            1: return int'(x1_real);
            2: return int'(x2_real);
            default: return int'(x3_real);
        endcase
    endfunction

    function automatic int gxi(input int k);
        case (k)
            0: return int'(x0_imag);
            1: return int'(x1_imag);
            2: return int'(x2_imag);
            default: return int'(x3_imag);
        endcase
    endfunction

    function automatic quad_t frm(input int a, input int b, input int c, input int d);
        quad_t q;
        q[0] = a[15:0];
        q[1] = b[15:0];
        q[2] = c[15:0];
        q[3] = d[15:0];
        return q;
    endfunction

    function automatic vec_t row(input logic v, input int re, input int im, input logic last,
                                 input logic mr, input logic sr, input logic mv, input logic err);
        vec_t r;
        r.v = v; r.re = re[15:0]; r.im = im[15:0]; r.last = last; r.mr = mr;
        r.e_sr = sr; r.e_mv = mv; r.e_err = err; r.cx = 1'b0;
        r.xr = '0; r.xi = '0;
        return r;
    endfunction

    task automatic chk_frame(input string tag, input quad_t er, input quad_t ei);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("%s x%0d_real", tag, k), gxr(k), int'($signed(er[k])));
            chk($sformatf("%s x%0d_imag", tag, k), gxi(k), int'($signed(ei[k])));
        end
    endtask

    task automatic chk_flags(input string tag, input int sr, input int mv, input int err);
        chk({tag, " s_ready"}, int'(s_ready), sr);
        chk({tag, " m_valid"}, int'(m_valid), mv);
        chk({tag, " err_align"}, int'(err_align), err);
    endtask

    task automatic chk_reset_state(input string tag);
        chk_flags(tag, 1, 0, 0);
        chk_frame(tag, '0, '0);
    endtask

    task automatic drive(input logic v, input int re, input int im, input logic last, input logic mr);
        @(negedge clk);
        s_valid = v; s_real = re[W-1:0]; s_imag = im[W-1:0]; s_last = last; m_ready = mr;
        #2;
    endtask

    task automatic pulse_reset(input string tag);
        @(negedge clk);
        s_valid = 1'b0; s_last = 1'b0; m_ready = 1'b0; rst = 1'b1;
        #2;
        chk_reset_state({tag, " asserted"});
        @(negedge clk);
        rst = 1'b0;
        #2;
        chk_reset_state({tag, " released"});
    endtask

    task automatic chk_fft(input string tag);
        int y0r, y0i, y1r, y1i, y2r, y3r, y3i;
        y0r = gxr(0) + gxr(1) + gxr(2) + gxr(3);
        y0i = gxi(0) + gxi(1) + gxi(2) + gxi(3);
        y1r = (gxr(0) - gxr(2)) + (gxi(1) - gxi(3));
        y1i = (gxi(0) - gxi(2)) - (gxr(1) - gxr(3));
        y2r = gxr(0) - gxr(1) + gxr(2) - gxr(3);
        y3r = (gxr(0) - gxr(2)) - (gxi(1) - gxi(3));
        y3i = (gxi(0) - gxi(2)) + (gxr(1) - gxr(3));
        chk({tag, " y0_real"}, y0r, 10000);
        chk({tag, " y0_imag"}, y0i, 0);
        chk({tag, " y1_real"}, y1r, -2000);
        chk({tag, " y1_imag"}, y1i, 2000);
        chk({tag, " y2_real"}, y2r, -2000);
        chk({tag, " y3_real"}, y3r, -2000);
        chk({tag, " y3_imag"}, y3i, -2000);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        // Basic frame, early s_last discard, missing s_last on the 4th sample.
        tbl[0]  = row(1, 1000,   0, 0, 1, 1, 0, 0); tbl[0].cx = 1'b1;
        tbl[1]  = row(1, 2000,   0, 0, 1, 1, 0, 0);
        tbl[2]  = row(1, 3000,   0, 0, 1, 1, 0, 0);
        tbl[3]  = row(1, 4000,   0, 1, 1, 1, 0, 0);
        tbl[4]  = row(0,    0,   0, 0, 1, 1, 1, 0); tbl[4].cx = 1'b1;
        tbl[4].xr = frm(1000, 2000, 3000, 4000);
        tbl[5]  = row(0,    0,   0, 0, 1, 1, 0, 0);
        tbl[6]  = row(1,    5,  -5, 0, 1, 1, 0, 0);
        tbl[7]  = row(1,    6,  -6, 1, 1, 1, 0, 0);
        tbl[8]  = row(1,    7,  -7, 0, 1, 1, 0, 1);
        tbl[9]  = row(1,    8,  -8, 0, 1, 1, 0, 0);
        tbl[10] = row(1,    9,  -9, 0, 1, 1, 0, 0);
        tbl[11] = row(1,   10, -10, 1, 1, 1, 0, 0);
        tbl[12] = row(0,    0,   0, 0, 0, 1, 1, 0); tbl[12].cx = 1'b1;
        tbl[12].xr = frm(7, 8, 9, 10); tbl[12].xi = frm(-7, -8, -9, -10);
        tbl[13] = tbl[12]; tbl[13].mr = 1'b1;
        tbl[14] = row(0,    0,   0, 0, 1, 1, 0, 0);
        tbl[15] = row(1,   11, -11, 0, 1, 1, 0, 0);
        tbl[16] = row(1,   12, -12, 0, 1, 1, 0, 0);
        tbl[17] = row(1,   13, -13, 0, 1, 1, 0, 0);
        tbl[18] = row(1,   14, -14, 0, 1, 1, 0, 0);
        tbl[19] = row(0,    0,   0, 0, 0, 1, 1, 1); tbl[19].cx = 1'b1;
        tbl[19].xr = frm(11, 12, 13, 14); tbl[19].xi = frm(-11, -12, -13, -14);
        tbl[20] = tbl[19]; tbl[20].mr = 1'b1; tbl[20].e_err = 1'b0;
        tbl[21] = row(0,    0,   0, 0, 1, 1, 0, 0);

        pulse_reset("reset");
        for (int i = 0; i < 22; i++) begin
            drive(tbl[i].v, int'(tbl[i].re), int'(tbl[i].im), tbl[i].last, tbl[i].mr);
            chk_flags($sformatf("row%0d", i), int'(tbl[i].e_sr), int'(tbl[i].e_mv), int'(tbl[i].e_err));
            if (tbl[i].cx) chk_frame($sformatf("row%0d", i), tbl[i].xr, tbl[i].xi);
            if (i == 4) chk_fft("row4 fft");
        end

        // Backpressure: both banks fill, a single pop frees one bank.
        pulse_reset("bp reset");
        for (int k = 0; k < 8; k++) begin
            drive(1, 100 + k, k, (k % 4) == 3, 0);
            chk($sformatf("bp accept%0d s_ready", k), int'(s_ready), 1);
        end
        for (int k = 0; k < 3; k++) begin
            drive(1, 108, 8, 0, 0);
            chk_flags($sformatf("bp stall%0d", k), 0, 1, 0);
            chk_frame($sformatf("bp stall%0d", k), frm(100, 101, 102, 103), frm(0, 1, 2, 3));
        end
        drive(1, 108, 8, 0, 1);
        chk_flags("bp pop", 0, 1, 0);
        chk_frame("bp pop", frm(100, 101, 102, 103), frm(0, 1, 2, 3));
        drive(1, 108, 8, 0, 0);
        chk_flags("bp release", 1, 1, 0);
        chk_frame("bp release", frm(104, 105, 106, 107), frm(4, 5, 6, 7));
        for (int k = 9; k < 12; k++) begin
            drive(1, 100 + k, k, k == 11, 0);
            chk_flags($sformatf("bp fill%0d", k), 1, 1, 0);
            chk_frame($sformatf("bp fill%0d", k), frm(104, 105, 106, 107), frm(4, 5, 6, 7));
        end
        drive(0, 0, 0, 0, 0);
        chk_flags("bp full again", 0, 1, 0);
        chk_frame("bp full again", frm(104, 105, 106, 107), frm(4, 5, 6, 7));
        drive(0, 0, 0, 0, 1);
        chk_flags("bp drain2", 0, 1, 0);
        drive(0, 0, 0, 0, 1);
        chk_flags("bp drain3", 1, 1, 0);
        chk_frame("bp drain3", frm(108, 109, 110, 111), frm(8, 9, 10, 11));
        drive(0, 0, 0, 0, 0);
        chk_flags("bp empty", 1, 0, 0);

        // Continuous stream with m_ready held high.
        pulse_reset("cont reset");
        for (int c = 0; c < 13; c++) begin
            int exp_mv;
            drive(c < 12, 200 + c, -c, (c % 4) == 3, 1);
            exp_mv = (c >= 4 && (c % 4) == 0) ? 1 : 0;
            chk_flags($sformatf("cont c%0d", c), 1, exp_mv, 0);
            if (exp_mv == 1) begin
                chk($sformatf("cont c%0d x0_real", c), gxr(0), 200 + c - 4);
                chk($sformatf("cont c%0d x3_real", c), gxr(3), 200 + c - 1);
                chk($sformatf("cont c%0d x3_imag", c), gxi(3), -(c - 1));
            end
        end

        // Reset mid-frame, then with a full frame pending and a partial one filling.
        pulse_reset("mid reset0");
        drive(1, 300, 1, 0, 0);
        drive(1, 301, 2, 0, 0);
        pulse_reset("mid reset1");
        for (int k = 0; k < 6; k++) drive(1, 400 + k, 0, k == 3, 0);
        chk_flags("mid pending", 1, 1, 0);
        pulse_reset("mid reset2");
        drive(0, 0, 0, 0, 0);
        chk_flags("mid after", 1, 0, 0);
        for (int k = 0; k < 4; k++) drive(1, 500 + k, 50 + k, k == 3, 0);
        drive(0, 0, 0, 0, 0);
        chk_flags("mid next frame", 1, 1, 0);
        chk_frame("mid next frame", frm(500, 501, 502, 503), frm(50, 51, 52, 53));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
